spm_host: RTL and testbench

SPM_HOST -- requirements
Module: spm_host

---
 rtl/spm_host_pkg.sv | 15 +
 rtl/spm_host_if.sv | 34 +++
 rtl/spm_host_timer.sv | 37 +++
 rtl/spm_host.sv | 125 ++++++++++++
 tb/tb_spm_host.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spm_host_pkg.sv
// Shared types and widths for the SPM host sequencer.
package spm_host_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    READ_LO,
    READ_HI,
    RESP
  } spm_state_e;

endpackage

// File: rtl/spm_host_if.sv
// Request/response bus toward the client and operand/product bus toward the multiplier.
interface spm_req_if;
  import spm_host_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_mc;
  logic [OP_W-1:0]   req_mp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PROD_W-1:0] rsp_prod;
  logic              rsp_timeout;

  modport master (output req_valid, req_mc, req_mp, rsp_ready,
                  input  req_ready, rsp_valid, rsp_prod, rsp_timeout);
  modport slave  (input  req_valid, req_mc, req_mp, rsp_ready,
                  output req_ready, rsp_valid, rsp_prod, rsp_timeout);
endinterface

interface spm_mul_if;
  import spm_host_pkg::*;

  logic [OP_W-1:0] spm_mc;
  logic [OP_W-1:0] spm_mp;
  logic            spm_start;
  logic            spm_prod_sel;
  logic [OP_W-1:0] spm_prod;
  logic            spm_done;

  modport master (output spm_mc, spm_mp, spm_start, spm_prod_sel,
                  input  spm_prod, spm_done);
  modport slave  (input  spm_mc, spm_mp, spm_start, spm_prod_sel,
                  output spm_prod, spm_done);
endinterface

// File: rtl/spm_host_timer.sv
// Saturating wait counter; tc_o marks the enabled cycle that brings the count to LIMIT.
module spm_host_timer #(
  parameter int LIMIT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int            CW   = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] LIM  = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST) || (cnt_q == LIM);

endmodule

// File: rtl/spm_host.sv
// Sequences one multiply: launch, wait for done or timeout, read both product halves, respond.
module spm_host import spm_host_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  spm_req_if.slave   req,
  spm_mul_if.master  mul
);

  spm_state_e        state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [PROD_W-1:0] rsp_prod_q, rsp_prod_d;
  logic              spm_start_q, spm_start_d;
  logic              prod_sel_q, prod_sel_d;
  logic [OP_W-1:0]   spm_mc_q, spm_mc_d;
  logic [OP_W-1:0]   spm_mp_q, spm_mp_d;
  logic              tmr_clr, tmr_en, tmr_tc;

  spm_host_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_prod_d    = rsp_prod_q;
    spm_start_d   = spm_start_q;
    prod_sel_d    = prod_sel_q;
    spm_mc_d      = spm_mc_q;
    spm_mp_d      = spm_mp_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.req_valid && req_ready_q) begin
          state_d     = RUN;
          spm_mc_d    = req.req_mc;
          spm_mp_d    = req.req_mp;
          spm_start_d = 1'b1;
          tmr_clr     = 1'b1;
        end else begin
          req_ready_d = !mul.spm_done;
        end
      end
      RUN: begin
        tmr_en = 1'b1;
        // done takes priority over a coincident timeout
        if (mul.spm_done) begin
          state_d     = READ_LO;
          spm_start_d = 1'b0;
          prod_sel_d  = 1'b0;
        end else if (tmr_tc) begin
          state_d       = RESP;
          spm_start_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          rsp_prod_d    = '0;
          rsp_valid_d   = 1'b1;
        end
      end
      READ_LO: begin
        rsp_prod_d[OP_W-1:0] = mul.spm_prod;
        prod_sel_d           = 1'b1;
        state_d              = READ_HI;
      end
      READ_HI: begin
        rsp_prod_d[PROD_W-1:OP_W] = mul.spm_prod;
        prod_sel_d                = 1'b0;
        rsp_valid_d               = 1'b1;
        rsp_timeout_d             = 1'b0;
        state_d                   = RESP;
      end
      RESP: begin
        if (req.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = !mul.spm_done;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_prod_q    <= '0;
      spm_start_q   <= 1'b0;
      prod_sel_q    <= 1'b0;
      spm_mc_q      <= '0;
      spm_mp_q      <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_prod_q    <= rsp_prod_d;
      spm_start_q   <= spm_start_d;
      prod_sel_q    <= prod_sel_d;
      spm_mc_q      <= spm_mc_d;
      spm_mp_q      <= spm_mp_d;
    end
  end

  assign req.req_ready    = req_ready_q;
  assign req.rsp_valid    = rsp_valid_q;
  assign req.rsp_timeout  = rsp_timeout_q;
  assign req.rsp_prod     = rsp_prod_q;
  assign mul.spm_start    = spm_start_q;
  assign mul.spm_prod_sel = prod_sel_q;
  assign mul.spm_mc       = spm_mc_q;
  assign mul.spm_mp       = spm_mp_q;

endmodule

// File: tb/tb_spm_host.sv
// Randomized bench for spm_host with a latency-programmable multiplier model and a transaction-level reference.
module tb_spm_host;
  import spm_host_pkg::*;

  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spm_req_if req_if ();
  spm_mul_if mul_if ();

  spm_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_if),
    .mul (mul_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Multiplier model: done rises after m_lat cycles of sampled start, stays high m_hold+1 cycles.
  int   m_lat   = 1;
  bit   m_never = 1'b0;
  int   m_hold  = 0;
  int   m_cnt;
  int   m_hold_cnt;
  logic [63:0] full_prod;

  assign full_prod       = {32'h0, mul_if.spm_mc} * {32'h0, mul_if.spm_mp};
  assign mul_if.spm_prod = mul_if.spm_prod_sel ? full_prod[63:32] : full_prod[31:0];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt           <= 0;
      m_hold_cnt      <= 0;
      mul_if.spm_done <= 1'b0;
    end else if (mul_if.spm_done) begin
      if (m_hold_cnt == 0) begin
        mul_if.spm_done <= 1'b0;
        m_cnt           <= 0;
      end else begin
        m_hold_cnt <= m_hold_cnt - 1;
      end
    end else if (mul_if.spm_start) begin
      if (!m_never && (m_cnt + 1 == m_lat)) begin
        mul_if.spm_done <= 1'b1;
        m_hold_cnt      <= m_hold;
      end
      m_cnt <= m_cnt + 1;
    end else begin
      m_cnt <= 0;
    end
  end

  task automatic send_req(input logic [31:0] mc, input logic [31:0] mp, output bit got);
    @(negedge clk);
    req_if.req_mc    = mc;
    req_if.req_mp    = mp;
    req_if.req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (req_if.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    check_val("req_accept", 64'(got), 64'd1);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [31:0] mc, input logic [31:0] mp, input int lat, input bit never,
                       input int hold, input int rdy_dly, input bit poke);
    logic [63:0] exp_prod;
    bit          exp_tmo, got, sel_m1, sel_m2, p_done;
    int          exp_start, start_n, done_cyc, valid_cyc, cyc;

    exp_tmo   = never || (lat >= TMO);
    exp_prod  = exp_tmo ? 64'h0 : ({32'h0, mc} * {32'h0, mp});
    exp_start = exp_tmo ? TMO : lat + 1;
    m_lat     = lat;
    m_never   = never;
    m_hold    = hold;

    send_req(mc, mp, got);
    if (!got) begin
      req_if.req_valid = 1'b0;
      return;
    end
    req_if.req_valid = poke;
    check_val("launch_start", 64'(mul_if.spm_start), 64'd1);
    check_val("launch_mc", 64'(mul_if.spm_mc), 64'(mc));
    check_val("launch_mp", 64'(mul_if.spm_mp), 64'(mp));

    cyc = 1; start_n = 0; done_cyc = 0; valid_cyc = 0; sel_m1 = 1'b0; sel_m2 = 1'b0;
    for (int i = 0; i < 1000 && valid_cyc == 0; i++) begin
      if (req_if.rsp_valid) begin
        valid_cyc = cyc;
      end else begin
        if (mul_if.spm_start) start_n++;
        if (done_cyc == 0 && mul_if.spm_done && mul_if.spm_start) done_cyc = cyc;
        if (poke) begin
          check_val("busy_req_ready", 64'(req_if.req_ready), 64'd0);
          req_if.req_mc = $urandom;
          req_if.req_mp = $urandom;
        end
        sel_m2 = sel_m1;
        sel_m1 = mul_if.spm_prod_sel;
        @(negedge clk);
        cyc++;
      end
    end
    check_val("rsp_valid_seen", 64'(valid_cyc != 0), 64'd1);
    check_val("start_cycles", 64'(start_n), 64'(exp_start));
    check_val("rsp_timeout", 64'(req_if.rsp_timeout), 64'(exp_tmo));
    check_val("rsp_prod", req_if.rsp_prod, exp_prod);
    check_val("mc_stable", 64'(mul_if.spm_mc), 64'(mc));
    if (!exp_tmo) begin
      check_val("done_to_valid", 64'(valid_cyc - done_cyc), 64'd3);
      check_val("sel_lo_then_hi", 64'({sel_m2, sel_m1}), 64'b01);
    end

    for (int k = 0; k < rdy_dly; k++) begin
      @(negedge clk);
      check_val("resp_hold_valid", 64'(req_if.rsp_valid), 64'd1);
      check_val("resp_hold_prod", req_if.rsp_prod, exp_prod);
      check_val("resp_hold_tmo", 64'(req_if.rsp_timeout), 64'(exp_tmo));
      check_val("resp_req_ready", 64'(req_if.req_ready), 64'd0);
    end
    req_if.req_valid = 1'b0;
    req_if.rsp_ready = 1'b1;
    p_done = mul_if.spm_done;
    @(negedge clk);
    req_if.rsp_ready = 1'b0;
    check_val("rsp_valid_clear", 64'(req_if.rsp_valid), 64'd0);
    check_val("rsp_prod_kept", req_if.rsp_prod, exp_prod);
    for (int k = 0; k < hold + 4; k++) begin
      check_val("ready_vs_done", 64'(req_if.req_ready), 64'(!p_done));
      p_done = mul_if.spm_done;
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_op();
    bit got;
    m_never = 1'b1;
    send_req($urandom, $urandom, got);
    req_if.req_valid = 1'b0;
    repeat (19) @(negedge clk);
    check_val("pre_rst_start", 64'(mul_if.spm_start), 64'd1);
    #2 rst = 1'b0;
    #1;
    check_val("rst_req_ready", 64'(req_if.req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(req_if.rsp_valid), 64'd0);
    check_val("rst_rsp_timeout", 64'(req_if.rsp_timeout), 64'd0);
    check_val("rst_rsp_prod", req_if.rsp_prod, 64'd0);
    check_val("rst_spm_start", 64'(mul_if.spm_start), 64'd0);
    check_val("rst_prod_sel", 64'(mul_if.spm_prod_sel), 64'd0);
    check_val("rst_spm_mc", 64'(mul_if.spm_mc), 64'd0);
    check_val("rst_spm_mp", 64'(mul_if.spm_mp), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 64'(req_if.req_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      check_val("post_rst_no_rsp", 64'(req_if.rsp_valid), 64'd0);
      @(negedge clk);
    end
    m_never = 1'b0;
  endtask

  initial begin
    rst              = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_mc    = '0;
    req_if.req_mp    = '0;
    req_if.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_req_ready", 64'(req_if.req_ready), 64'd0);
    check_val("reset_rsp_valid", 64'(req_if.rsp_valid), 64'd0);
    check_val("reset_spm_start", 64'(mul_if.spm_start), 64'd0);
    check_val("reset_rsp_prod", req_if.rsp_prod, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("idle_req_ready", 64'(req_if.req_ready), 64'd1);

    do_op(32'h0000_0003, 32'h0000_0005, 64, 1'b0, 0, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0, 1, 2, 1'b0);
    do_op($urandom, $urandom, 0, 1'b1, 0, 1, 1'b0);
    do_op($urandom, $urandom, TMO - 1, 1'b0, 0, 0, 1'b0);
    do_op($urandom, $urandom, TMO, 1'b0, 3, 0, 1'b0);
    do_op($urandom, $urandom, 30, 1'b0, 20, 10, 1'b1);
    reset_mid_op();
    do_op($urandom, $urandom, 17, 1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      do_op($urandom, $urandom, int'($urandom_range(1, 120)), 1'b0,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
